// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - PS/2 frame receiver feeding a show-ahead byte FIFO; PS2_PARITY_CHECK_EN enables parity rejection
module ps2_rx_fifo #(
    parameter int DEPTH          = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       ps2_clk,
    input  logic                       ps2_dat,
    input  logic                       rd_en,
    output logic [7:0]                 rd_data,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    input  logic                       ovf_clr,
    output logic                       overflow,
    output logic                       frame_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] FULL_COUNT   = CW'(DEPTH);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] dat_sync_q;
    logic                   clk_prev_q;
    logic                   clk_s;
    logic                   dat_s;
    logic                   fall;

    state_t          state_q, state_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            frame_err_q, frame_err_d;
    logic            wr_req;
    logic            parity_ok;

    logic [7:0]      mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            overflow_q;
    logic            full;
    logic            do_pop;
    logic            do_write;
    logic            drop;

    // Lines idle high, so synchronisers reset to 1 to avoid a phantom edge after reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            clk_prev_q <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
            dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_dat};
            clk_prev_q <= clk_s;
        end
    end

    assign clk_s = clk_sync_q[SYNC_STAGES-1];
    assign dat_s = dat_sync_q[SYNC_STAGES-1];
    assign fall  = clk_prev_q & ~clk_s;

`ifdef PS2_PARITY_CHECK_EN
    logic parity_q, parity_d;
    assign parity_ok = ^{shift_q, parity_q};
`else
    assign parity_ok = 1'b1;
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            timer_q     <= '0;
            frame_err_q <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            timer_q     <= timer_d;
            frame_err_q <= frame_err_d;
`ifdef PS2_PARITY_CHECK_EN
            parity_q    <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        wr_req      = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
        parity_d    = parity_q;
`endif
        if (state_q == ST_IDLE || fall) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + TW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (fall && !dat_s) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (fall) begin
                    shift_d   = {dat_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (fall) begin
`ifdef PS2_PARITY_CHECK_EN
                    parity_d = dat_s;
`endif
                    state_d  = ST_STOP;
                end
            end
            ST_STOP: begin
                if (fall) begin
                    state_d = ST_IDLE;
                    if (dat_s && parity_ok) begin
                        wr_req = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_q != ST_IDLE && !fall && timer_q == TIMEOUT_LAST) begin
            state_d     = ST_IDLE;
            frame_err_d = 1'b1;
        end
    end

    // A pop in the same cycle frees the slot, so a write into a full FIFO still lands.
    assign full     = (count_q == FULL_COUNT);
    assign do_pop   = rd_en && (count_q != '0);
    assign do_write = wr_req && (!full || do_pop);
    assign drop     = wr_req && full && !do_pop;

    always_ff @(posedge clock) begin
        if (do_write) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_write) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_write, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            overflow_q <= drop | (overflow_q & ~ovf_clr);
        end
    end

    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign rd_data   = empty ? 8'h00 : mem_q[rd_ptr_q];
    assign overflow  = overflow_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb/tb_ps2_rx_fifo.sv - directed bench for ps2_rx_fifo with queue-based reference model
module tb_ps2_rx_fifo;

    localparam int DEPTH = 8;
    localparam int SYNC  = 2;
    localparam int TMO   = 50000;
`ifdef PS2_PARITY_CHECK_EN
    localparam bit PCHK = 1'b1;
`else
    localparam bit PCHK = 1'b0;
`endif

    logic       clock   = 1'b0;
    logic       reset_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic       rd_en   = 1'b0;
    logic       ovf_clr = 1'b0;
    logic [7:0] rd_data;
    logic       empty;
    logic [3:0] count;
    logic       overflow;
    logic       frame_err;

    logic [7:0] mq[$];
    bit         m_ovf    = 1'b0;
    bit         exp_ferr = 1'b0;
    bit         chk_en   = 1'b0;
    int         n_pass   = 0;
    int         n_total  = 0;

    ps2_rx_fifo #(.DEPTH(DEPTH), .SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .ps2_clk   (ps2_clk),
        .ps2_dat   (ps2_dat),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .empty     (empty),
        .count     (count),
        .ovf_clr   (ovf_clr),
        .overflow  (overflow),
        .frame_err (frame_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            check("empty", 32'(empty), 32'(mq.size() == 0));
            check("count", 32'(count), 32'(mq.size()));
            check("overflow", 32'(overflow), 32'(m_ovf));
            check("frame_err", 32'(frame_err), 32'(exp_ferr));
            if (mq.size() > 0) begin
                check("rd_data", 32'(rd_data), 32'(mq[0]));
            end
        end
    end

    task automatic send_bit(input logic b);
        @(negedge clock);
        ps2_dat = b;
        repeat (3) @(negedge clock);
        ps2_clk = 1'b0;
        repeat (8) @(negedge clock);
        ps2_clk = 1'b1;
        repeat (3) @(negedge clock);
    endtask

    // side: 0 none, 1 rd_en and 2 ovf_clr in the cycle the stop edge is acted on
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input int side);
        bit ok;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            send_bit(d[i]);
        end
        send_bit(par);
        @(negedge clock);
        ps2_dat = stop;
        repeat (3) @(negedge clock);
        ps2_clk = 1'b0;
        repeat (SYNC) @(posedge clock);
        if (side == 1) begin
            @(negedge clock);
            rd_en = 1'b1;
        end else if (side == 2) begin
            @(negedge clock);
            ovf_clr = 1'b1;
        end
        @(posedge clock);
        #1;
        rd_en   = 1'b0;
        ovf_clr = 1'b0;
        ok = stop && (!PCHK || (^{d, par}));
        if (side == 1 && mq.size() > 0) begin
            void'(mq.pop_front());
        end
        if (side == 2) begin
            m_ovf = 1'b0;
        end
        if (ok) begin
            if (mq.size() < DEPTH) begin
                mq.push_back(d);
            end else begin
                m_ovf = 1'b1;
            end
        end else begin
            exp_ferr = 1'b1;
        end
        @(posedge clock);
        #1;
        exp_ferr = 1'b0;
        repeat (6) @(negedge clock);
        ps2_clk = 1'b1;
        repeat (3) @(negedge clock);
    endtask

    task automatic good_frame(input logic [7:0] d, input int side);
        send_frame(d, ~^d, 1'b1, side);
    endtask

    task automatic pop_expect(input logic [7:0] lit);
        @(negedge clock);
        #1;
        check("pop_value", 32'(rd_data), 32'(lit));
        rd_en = 1'b1;
        @(posedge clock);
        #1;
        rd_en = 1'b0;
        if (mq.size() > 0) begin
            void'(mq.pop_front());
        end
    endtask

    task automatic lit_check(input string name, input logic [31:0] act, input logic [31:0] exp);
        @(negedge clock);
        #1;
        check(name, act, exp);
    endtask

    initial begin
        logic [7:0] b;

        repeat (3) @(posedge clock);
        @(negedge clock);
        #1;
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_count", 32'(count), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'h00);
        reset_n = 1'b1;
        chk_en  = 1'b1;

        send_frame(8'h1C, 1'b0, 1'b1, 0);
        lit_check("one_count", 32'(count), 32'd1);
        lit_check("one_rd_data", 32'(rd_data), 32'h1C);
        lit_check("one_empty", 32'(empty), 32'd0);
        pop_expect(8'h1C);
        lit_check("one_popped_empty", 32'(empty), 32'd1);

        @(negedge clock);
        rd_en = 1'b1;
        @(posedge clock);
        #1;
        rd_en = 1'b0;
        lit_check("pop_when_empty_count", 32'(count), 32'd0);

        send_frame(8'hF0, 1'b1, 1'b1, 0);
        send_frame(8'h1C, 1'b0, 1'b1, 0);
        pop_expect(8'hF0);
        pop_expect(8'h1C);

        send_frame(8'h1C, 1'b1, 1'b1, 0);
`ifdef PS2_PARITY_CHECK_EN
        lit_check("bad_parity_empty", 32'(empty), 32'd1);
`else
        lit_check("bad_parity_kept", 32'(rd_data), 32'h1C);
        pop_expect(8'h1C);
`endif

        send_frame(8'h33, 1'b1, 1'b0, 0);
        lit_check("bad_stop_empty", 32'(empty), 32'd1);

        for (int i = 1; i <= 9; i++) begin
            b = 8'(i);
            good_frame(b, 0);
        end
        lit_check("ovf_count", 32'(count), 32'd8);
        lit_check("ovf_set", 32'(overflow), 32'd1);
        good_frame(8'h0A, 2);
        lit_check("ovf_clr_coincide", 32'(overflow), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            b = 8'(i);
            pop_expect(b);
        end
        @(negedge clock);
        ovf_clr = 1'b1;
        @(posedge clock);
        #1;
        ovf_clr = 1'b0;
        m_ovf   = 1'b0;
        lit_check("ovf_cleared", 32'(overflow), 32'd0);

        for (int i = 0; i < 8; i++) begin
            b = 8'h10 + 8'(i);
            good_frame(b, 0);
        end
        good_frame(8'h18, 1);
        lit_check("full_wr_pop_count", 32'(count), 32'd8);
        lit_check("full_wr_pop_ovf", 32'(overflow), 32'd0);
        for (int i = 1; i <= 8; i++) begin
            b = 8'h10 + 8'(i);
            pop_expect(b);
        end

        send_bit(1'b1);
        repeat (20) @(negedge clock);
        lit_check("start_one_idle", 32'(empty), 32'd1);

        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        @(negedge clock);
        ps2_dat = 1'b1;
        repeat (3) @(negedge clock);
        ps2_clk = 1'b0;
        repeat (SYNC + 1) @(posedge clock);
        #1;
        repeat (5) @(posedge clock);
        #1;
        ps2_clk = 1'b1;
        repeat (TMO - 5) @(posedge clock);
        #1;
        exp_ferr = 1'b1;
        check("timeout_pulse", 32'(frame_err), 32'd1);
        @(posedge clock);
        #1;
        exp_ferr = 1'b0;
        check("timeout_pulse_end", 32'(frame_err), 32'd0);
        good_frame(8'h29, 0);
        pop_expect(8'h29);

        send_bit(1'b0);
        for (int i = 0; i < 5; i++) begin
            send_bit(1'(i % 2));
        end
        @(negedge clock);
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        mq.delete();
        m_ovf    = 1'b0;
        exp_ferr = 1'b0;
        lit_check("midframe_rst_empty", 32'(empty), 32'd1);
        good_frame(8'h5A, 0);
        pop_expect(8'h5A);

        repeat (5) @(negedge clock);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ps2_rx_fifo.md
PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning FIFO depth in bytes (power of 2, 2..64).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning synchroniser flops per PS/2 line (2..4).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 50000, meaning max clock cycles between PS/2 falling edges inside a frame (1 ms at 50 MHz).
REQ-004 SHALL have port clock, input, 1, 50 MHz system clock; all logic on rising edge.
REQ-005 SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-006 SHALL have port ps2_clk, input, 1, asynchronous PS/2 clock line.
REQ-007 SHALL have port ps2_dat, input, 1, asynchronous PS/2 data line.
REQ-008 SHALL have port rd_en, input, 1, pop request.
REQ-009 SHALL have port rd_data, output, 8, head-of-FIFO byte (show-ahead).
REQ-010 SHALL have port empty, output, 1, FIFO holds no bytes.
REQ-011 SHALL have port count, output, $clog2(DEPTH+1), bytes held.
REQ-012 SHALL have port ovf_clr, input, 1, clears overflow.
REQ-013 SHALL have port overflow, output, 1, sticky: a byte was dropped because the FIFO was full.
REQ-014 SHALL have port frame_err, output, 1, one-cycle pulse per rejected frame.

Function
REQ-015 SHALL pass ps2_clk and ps2_dat through SYNC_STAGES flops; a falling edge is synced clk 1 -> 0 between consecutive cycles.
REQ-016 SHALL use frame format: start 0, 8 data bits LSB first, odd parity, stop 1, each sampled on a falling edge.
REQ-017 SHALL run FSM IDLE -> DATA (8 edges) -> PARITY -> STOP -> IDLE.
REQ-018 SHALL stay in IDLE without error when the start bit samples 1.
REQ-019 SHALL pulse frame_err, discard the byte, and return to IDLE when the stop bit samples 0.
REQ-020 SHALL reload a timeout counter on every falling edge outside IDLE; on reaching TIMEOUT_CYCLES it SHALL pulse frame_err, discard the partial byte, and return to IDLE.
REQ-021 SHALL write an accepted byte in the cycle the stop edge is detected; empty deasserts and rd_data is valid the following cycle.
REQ-022 SHALL pop the head on rd_en while empty=0; rd_en while empty=1 SHALL be ignored and SHALL NOT change count.
REQ-023 SHALL, on write and pop in the same cycle, complete both, including when full; count is unchanged.
REQ-024 SHALL, on write when full without a pop, drop the byte, leave FIFO contents intact, and set overflow.
REQ-025 SHALL hold overflow until ovf_clr or reset; if ovf_clr and a new overflow coincide, overflow SHALL remain set.
REQ-026 SHALL wrap read/write pointers modulo DEPTH, with full at count=DEPTH.

Reset
REQ-027 SHALL, with reset_n low at a clock edge: FSM to IDLE, pointers and count to 0, empty=1, overflow=0, frame_err=0, rd_data=0, synchronisers to 1.
REQ-028 SHALL discard a frame in progress when reset asserts mid-frame, without a frame_err pulse; reception resumes with the next start bit after release.

Configuration
REQ-029 SHALL, with PS2_PARITY_CHECK_EN defined, reject a frame whose data+parity has an even count of ones: frame_err pulse, byte not written.
REQ-030 SHALL, without PS2_PARITY_CHECK_EN, sample and ignore the parity bit and never raise frame_err for parity.

Verification
REQ-031 SHALL cover: frame 0x1C, parity 0 -> count=1, rd_data=0x1C, empty=0; one rd_en -> empty=1.
REQ-032 SHALL cover: frames 0xF0 (parity 1) then 0x1C -> popped in order 0xF0, 0x1C.
REQ-033 SHALL cover: 0x1C with parity 1 -> with macro: frame_err one pulse, empty=1; without macro: rd_data=0x1C.
REQ-034 SHALL cover: DEPTH=8, 9 frames 0x01..0x09, no reads -> count=8, overflow=1, pops 0x01..0x08; ovf_clr -> overflow=0.
REQ-035 SHALL cover: start + 3 data bits then ps2_clk held high -> frame_err at edge+50000 cycles; next frame 0x29 received correctly.
REQ-036 SHALL cover: reset_n low for one cycle after 5 data bits -> no frame_err, empty=1; next frame 0x5A received.
